// File: rtl/alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_arbiter
// Brief    : Two-port round-robin issue controller for the shared scalar ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_arbiter #(
    parameter int WIDTH       = 36,
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_CYCLES  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_cmp,
    output logic             busy
);

    localparam int c_max_cycles = (MUL_CYCLES > EXEC_CYCLES) ? MUL_CYCLES : EXEC_CYCLES;
    localparam int c_cnt_w      = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_mul_load  = c_cnt_w'(MUL_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_exec_load = c_cnt_w'(EXEC_CYCLES - 1);
    localparam logic [3:0]         c_op_mul    = 4'b0010;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_last_id;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_id;
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_id;
    logic               r_resp_cmp;

    logic               w_idle;
    logic               w_grant0;
    logic               w_grant1;
    logic               w_accept;
    logic [3:0]         w_op;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    // A lone requester always wins; on contention the port that did not finish last wins.
    assign w_idle   = (r_state == c_st_idle) && !rst;
    assign w_grant0 = req0_valid && (!req1_valid || r_last_id);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_id);

    assign req0_ready = w_idle && w_grant0;
    assign req1_ready = w_idle && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign w_op = req1_ready ? req1_op : req0_op;
    assign w_a  = req1_ready ? req1_a  : req0_a;
    assign w_b  = req1_ready ? req1_b  : req0_b;

    // ALU sees zeros (op[3] clear) outside EXEC so its compare flags hold.
    assign alu_op = (r_state == c_st_exec) ? r_op : 4'b0000;
    assign alu_a  = (r_state == c_st_exec) ? r_a  : '0;
    assign alu_b  = (r_state == c_st_exec) ? r_b  : '0;

    assign resp_valid = (r_state == c_st_resp);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_cmp   = r_resp_cmp;
    assign busy       = (r_state != c_st_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_last_id   <= 1'b1;
            r_op        <= 4'b0000;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_resp_data <= '0;
            r_resp_id   <= 1'b0;
            r_resp_cmp  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_a     <= w_a;
                        r_b     <= w_b;
                        r_id    <= req1_ready;
                        r_cnt   <= (w_op == c_op_mul) ? c_mul_load : c_exec_load;
                        r_state <= c_st_exec;
                    end
                end
                c_st_exec: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end else begin
                        r_resp_data <= alu_out;
                        r_resp_cmp  <= r_op[3];
                        r_resp_id   <= r_id;
                        r_state     <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (resp_ready) begin
                        r_last_id <= r_id;
                        r_state   <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_arbiter
// Brief    : Directed scenarios plus a randomized run against a timing/arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_arbiter;

    localparam int WIDTH       = 36;
    localparam int EXEC_CYCLES = 1;
    localparam int MUL_CYCLES  = 3;
    localparam int NCYC        = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic             resp_valid, resp_ready, resp_id, resp_cmp, busy;
    logic [WIDTH-1:0] resp_data;
    logic             lz, ez;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_issue_arbiter #(
        .WIDTH(WIDTH), .EXEC_CYCLES(EXEC_CYCLES), .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_cmp(resp_cmp), .busy(busy)
    );

    // Behavioural stand-in for the shared ALU.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            4'h1:    return a + b;
            4'h2:    return a * b;
            4'h3:    return a - b;
            4'h4:    return a & b;
            4'h5:    return a | b;
            4'h6:    return a ^ b;
            4'h7:    return a;
            4'h8:    return a - b;
            default: return '0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op, alu_a, alu_b);

    always @(posedge clk) begin
        if (alu_op[3]) begin
            lz <= (alu_a < alu_b);
            ez <= (alu_a == alu_b);
        end
    end

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    // Advance to the drive/sample point 3 time units after the next rising edge.
    task automatic next();
        @(posedge clk);
        #3;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        next();
        next();
        #1;
        vectors++;
        if ({req0_ready, req1_ready, busy, resp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: ready0/ready1/busy/resp_valid=%b required 0000",
                     {req0_ready, req1_ready, busy, resp_valid});
        end
        vectors++;
        if (alu_op !== 4'h0 || alu_a !== '0 || alu_b !== '0) begin
            errors++;
            $display("FAIL reset_alu: op=%h a=%h b=%h required zeros", alu_op, alu_a, alu_b);
        end
        vectors++;
        if (resp_data !== '0 || resp_id !== 1'b0 || resp_cmp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: data=%h id=%b cmp=%b required zeros", resp_data, resp_id, resp_cmp);
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        next();
    endtask

    task automatic test_add();
        req0_op = 4'h1; req0_a = 36'd5; req0_b = 36'd7; req0_valid = 1'b1; resp_ready = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_grant: ready0/ready1=%b required 10", {req0_ready, req1_ready});
        end
        next();
        req0_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || alu_op !== 4'h1 || alu_a !== 36'd5 || alu_b !== 36'd7 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: busy=%b op=%h a=%0d b=%0d rv=%b required 1/1/5/7/0",
                     busy, alu_op, alu_a, alu_b, resp_valid);
        end
        next();
        vectors++;
        if (resp_valid !== 1'b1 || resp_data !== 36'd12 || resp_id !== 1'b0 || resp_cmp !== 1'b0) begin
            errors++;
            $display("FAIL add_resp: rv=%b data=%0d id=%b cmp=%b required 1/12/0/0",
                     resp_valid, resp_data, resp_id, resp_cmp);
        end
        next();
        vectors++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_done: busy=%b rv=%b required 0/0", busy, resp_valid);
        end
    endtask

    task automatic test_mul();
        int ops, vcyc;
        logic [WIDTH-1:0] data;
        logic id;
        ops = 0; vcyc = -1; data = '0; id = 1'b0;
        req1_op = 4'h2; req1_a = 36'd6; req1_b = 36'd9; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mul_grant: ready0/ready1=%b required 01", {req0_ready, req1_ready});
        end
        for (int k = 1; k <= 12; k++) begin
            next();
            if (k == 1) req1_valid = 1'b0;
            if (alu_op == 4'h2) ops++;
            if (resp_valid && vcyc < 0) begin
                vcyc = k; data = resp_data; id = resp_id;
            end
            if (!busy) break;
        end
        vectors++;
        if (ops != MUL_CYCLES) begin
            errors++;
            $display("FAIL mul_hold: alu_op=MUL for %0d cycles required %0d", ops, MUL_CYCLES);
        end
        vectors++;
        if (vcyc != MUL_CYCLES + 1 || data !== 36'd54 || id !== 1'b1) begin
            errors++;
            $display("FAIL mul_resp: valid at T+%0d data=%0d id=%b required T+%0d/54/1",
                     vcyc, data, id, MUL_CYCLES + 1);
        end
    endtask

    task automatic test_alternate();
        int ids[$];
        int acc[$];
        logic [WIDTH-1:0] expq[$];
        logic [WIDTH-1:0] got;
        req0_op = 4'h1; req1_op = 4'h1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int k = 0; k < 60 && ids.size() < 6; k++) begin
            req0_a = rnd_word(); req0_b = rnd_word(); req1_a = rnd_word(); req1_b = rnd_word();
            #1;
            if (req0_ready) begin expq.push_back(req0_a + req0_b); acc.push_back(k); end
            if (req1_ready) begin expq.push_back(req1_a + req1_b); acc.push_back(k); end
            if (resp_valid && expq.size() > 0) begin
                got = expq.pop_front();
                vectors++;
                if (resp_data !== got) begin
                    errors++;
                    $display("FAIL alt_data: data=%h required %h", resp_data, got);
                end
                ids.push_back(int'(resp_id));
            end
            next();
            if (ids.size() >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        vectors++;
        if (ids.size() != 6) begin
            errors++;
            $display("FAIL alt_count: %0d responses required 6", ids.size());
        end
        for (int i = 0; i < ids.size(); i++) begin
            vectors++;
            if (ids[i] != (i % 2)) begin
                errors++;
                $display("FAIL alt_order: grant %0d went to port %0d required %0d", i, ids[i], i % 2);
            end
        end
        for (int i = 0; i + 1 < acc.size() && i < 5; i++) begin
            vectors++;
            if (acc[i+1] - acc[i] != EXEC_CYCLES + 2) begin
                errors++;
                $display("FAIL alt_interval: issue gap %0d required %0d", acc[i+1] - acc[i], EXEC_CYCLES + 2);
            end
        end
    endtask

    task automatic test_cmp_stall();
        bit seen;
        seen = 1'b0;
        req0_op = 4'h8; req0_a = 36'd3; req0_b = 36'd8; req0_valid = 1'b1;
        req1_op = 4'h1; req1_a = 36'd1; req1_b = 36'd1; req1_valid = 1'b1;
        resp_ready = 1'b0;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL cmp_grant: ready0/ready1=%b required 10", {req0_ready, req1_ready});
        end
        for (int k = 0; k < 10 && !seen; k++) begin
            next();
            req0_valid = 1'b0;
            #1;
            seen = resp_valid;
            vectors++;
            if (req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL cmp_wait_ready: ready1=%b required 0", req1_ready);
            end
        end
        vectors++;
        if (!seen) begin
            errors++;
            $display("FAIL cmp_timeout: resp_valid=0 required 1");
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (resp_valid !== 1'b1 || resp_data !== 36'hFFFFFFFFB || resp_cmp !== 1'b1 || resp_id !== 1'b0) begin
                errors++;
                $display("FAIL cmp_stall: rv=%b data=%h cmp=%b id=%b required 1/FFFFFFFFB/1/0",
                         resp_valid, resp_data, resp_cmp, resp_id);
            end
            vectors++;
            if (alu_op !== 4'h0 || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
                errors++;
                $display("FAIL cmp_stall_idle: alu_op=%h ready0=%b ready1=%b required 0/0/0",
                         alu_op, req0_ready, req1_ready);
            end
            next();
            #1;
        end
        vectors++;
        if (lz !== 1'b1 || ez !== 1'b0) begin
            errors++;
            $display("FAIL cmp_flags: lz=%b ez=%b required 1/0", lz, ez);
        end
        resp_ready = 1'b1;
        next();
        #1;
        vectors++;
        if (req1_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmp_release: ready1=%b busy=%b required 1/0", req1_ready, busy);
        end
        req1_valid = 1'b0;
        next();
    endtask

    task automatic test_reset_mid_mul();
        bit leaked;
        leaked = 1'b0;
        req1_op = 4'h2; req1_a = 36'd11; req1_b = 36'd13; req1_valid = 1'b1; resp_ready = 1'b1;
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmul_grant: ready1=%b required 1", req1_ready);
        end
        next();
        req1_valid = 1'b0;
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        vectors++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || alu_op !== 4'h0) begin
            errors++;
            $display("FAIL rmul_drop: busy=%b rv=%b alu_op=%h required 0/0/0", busy, resp_valid, alu_op);
        end
        for (int k = 0; k < 8; k++) begin
            if (resp_valid) leaked = 1'b1;
            next();
        end
        vectors++;
        if (leaked) begin
            errors++;
            $display("FAIL rmul_leak: resp_valid=1 after reset required 0");
        end
        req0_op = 4'h1; req1_op = 4'h1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rmul_priority: ready0/ready1=%b required 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        next();
    endtask

    task automatic test_illegal_op();
        bit seen;
        seen = 1'b0;
        req0_op = 4'hF; req0_a = 36'd1; req0_b = 36'd1; req0_valid = 1'b1; resp_ready = 1'b1;
        for (int k = 0; k < 10 && !seen; k++) begin
            next();
            req0_valid = 1'b0;
            seen = resp_valid;
        end
        vectors++;
        if (!seen || resp_data !== '0 || resp_cmp !== 1'b1 || resp_id !== 1'b0) begin
            errors++;
            $display("FAIL illegal_resp: seen=%b data=%h cmp=%b id=%b required 1/0/1/0",
                     seen, resp_data, resp_cmp, resp_id);
        end
        next();
        vectors++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_done: busy=%b rv=%b required 0/0", busy, resp_valid);
        end
    endtask

    // Model: one op outstanding; ALU active cycles acc+1..acc+n, response from acc+n+1.
    task automatic test_random();
        bit m_out, m_last, m_id, e0, e1, active, exp_valid, drain;
        logic [3:0] m_op, eop;
        logic [WIDTH-1:0] m_a, m_b, m_data, ea, eb;
        int m_acc, m_n;
        m_out = 1'b0; m_last = 1'b1; m_id = 1'b0; m_op = 4'h0; m_a = '0; m_b = '0;
        m_data = '0; m_acc = 0; m_n = 1;
        rst = 1'b1;
        next();
        rst = 1'b0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drain = (cyc >= NCYC - 12);
            req0_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
            req1_valid = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
            req0_op = 4'($urandom_range(0, 15)); req1_op = 4'($urandom_range(0, 15));
            req0_a = rnd_word(); req0_b = rnd_word(); req1_a = rnd_word(); req1_b = rnd_word();
            resp_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            vectors++;
            if (busy !== m_out) begin
                errors++;
                $display("FAIL rnd_busy: cyc %0d busy=%b required %b", cyc, busy, m_out);
            end
            e0 = !m_out && req0_valid && (!req1_valid || m_last);
            e1 = !m_out && req1_valid && (!req0_valid || !m_last);
            vectors++;
            if ({req0_ready, req1_ready} !== {e0, e1}) begin
                errors++;
                $display("FAIL rnd_grant: cyc %0d ready0/ready1=%b required %b", cyc,
                         {req0_ready, req1_ready}, {e0, e1});
            end
            active = m_out && (cyc >= m_acc + 1) && (cyc <= m_acc + m_n);
            eop = active ? m_op : 4'h0;
            ea  = active ? m_a : '0;
            eb  = active ? m_b : '0;
            vectors++;
            if (alu_op !== eop || alu_a !== ea || alu_b !== eb) begin
                errors++;
                $display("FAIL rnd_alu: cyc %0d op=%h a=%h b=%h required %h/%h/%h",
                         cyc, alu_op, alu_a, alu_b, eop, ea, eb);
            end
            exp_valid = m_out && (cyc >= m_acc + m_n + 1);
            vectors++;
            if (resp_valid !== exp_valid) begin
                errors++;
                $display("FAIL rnd_valid: cyc %0d resp_valid=%b required %b", cyc, resp_valid, exp_valid);
            end
            if (exp_valid && resp_valid) begin
                vectors++;
                if (resp_data !== m_data || resp_id !== m_id || resp_cmp !== m_op[3]) begin
                    errors++;
                    $display("FAIL rnd_resp: cyc %0d data=%h id=%b cmp=%b required %h/%b/%b",
                             cyc, resp_data, resp_id, resp_cmp, m_data, m_id, m_op[3]);
                end
            end
            if (exp_valid && resp_ready) begin
                m_last = m_id;
                m_out  = 1'b0;
            end else if (e0 || e1) begin
                m_id   = e1;
                m_op   = e1 ? req1_op : req0_op;
                m_a    = e1 ? req1_a : req0_a;
                m_b    = e1 ? req1_b : req0_b;
                m_n    = (m_op == 4'b0010) ? MUL_CYCLES : EXEC_CYCLES;
                m_data = alu_fn(m_op, m_a, m_b);
                m_acc  = cyc;
                m_out  = 1'b1;
            end
            next();
        end
        vectors++;
        if (m_out || busy) begin
            errors++;
            $display("FAIL rnd_drain: busy=%b outstanding=%b required 0/0", busy, m_out);
        end
    endtask

    initial begin
        rst = 1'b1; resp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 4'h0; req1_op = 4'h0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        test_reset();
        test_add();
        test_mul();
        test_alternate();
        test_cmp_stall();
        test_reset_mid_mul();
        test_illegal_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_arbiter.md
# alu_issue_arbiter

Two-port round-robin issue controller for the shared 36-bit scalar ALU. Accepts operation requests (op, A, B) from two requesters over valid/ready handshakes and grants one at a time. Holds the ALU inputs stable for the op-dependent execution time, captures the result and returns it with a requester ID over a valid/ready response channel. Sits between the scalar-pipe/vector-scalar requesters and the ALU instance, and keeps the ALU's registered compare flags untouched between operations.

## Interface
- WIDTH, 36, operand/result width
- EXEC_CYCLES, 1, ALU hold cycles for all ops except multiply (≥1)
- MUL_CYCLES, 3, ALU hold cycles for op 4'b0010 (≥1)

- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  4  ALU opcode
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- alu_op  out  4  to ALU op
- alu_a, alu_b  out  WIDTH  to ALU A, B
- alu_out  in  WIDTH  ALU result
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  owning requester (0/1)
- resp_data  out  WIDTH  captured result
- resp_cmp  out  1  op[3] of the completed op (ALU flags were updated)
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, EXEC, RESP.
- IDLE:
  - If no request is valid, stay.
  - Else grant: if exactly one port is valid, that port wins. If both are valid, the port ≠ last_id wins.
  - reqN_ready=1 combinationally for the winner only; readys are 0 in every other state.
  - On accept: latch op/a/b into op_r/a_r/b_r and id into id_r.
  - Load cnt = (op==4'b0010 ? MUL_CYCLES : EXEC_CYCLES) − 1, then go to EXEC.
- EXEC:
  - alu_op/alu_a/alu_b = op_r/a_r/b_r.
  - cnt≠0: decrement.
  - cnt==0: resp_data ← alu_out, resp_cmp ← op_r[3], resp_id ← id_r; go to RESP.
- RESP:
  - resp_valid=1. resp_data/id/cmp stay stable until the handshake.
  - On resp_valid&resp_ready: last_id ← id_r, go to IDLE.
- Outside EXEC: alu_op=4'b0000, alu_a=alu_b=0. op[3] is never set outside EXEC, so the ALU flags hold.
- Opcodes 4'b1001–4'b1111 are forwarded unchanged; the result is whatever the ALU returns (0); no error path.
- Request inputs are sampled only at accept. Changes to an unaccepted request are allowed.
- One operation is outstanding at a time. Requests wait while busy.

## Timing
- Reset (sync, rst=1 at posedge): state=IDLE, last_id=1 (port 0 has first priority), cnt=0, all *_r=0, resp_valid=0, resp_data=0, resp_id=0, resp_cmp=0, busy=0, readys=0, alu_* idle values.
- rst has priority over every event. Reset mid-EXEC or mid-RESP drops the operation; no response is produced.
- Accept at edge T (valid&ready high in cycle T).
- ALU driven from cycle T+1 through T+N, where N = MUL_CYCLES for multiply, else EXEC_CYCLES.
- resp_valid rises in cycle T+N+1.
- With resp_ready held high, the response completes in cycle T+N+1 and the next accept can occur in cycle T+N+2. Minimum issue interval is N+2 cycles.
- resp_ready low stalls indefinitely in RESP; the ALU stays idle.
- Compare op (4'b1000): the ALU flag registers update at each EXEC edge (same value). Flags are valid from cycle T+2 onward and remain until the next compare.
- Both ports valid continuously: grants alternate 0,1,0,1…
- A single requester valid continuously is granted every interval regardless of last_id.

## Test plan
- Reset, then req0 ADD a=5 b=7 with resp_ready=1 (EXEC_CYCLES=1):
  - req0_ready high in cycle 0, resp_valid high in cycle 2 with resp_data=12, resp_id=0, resp_cmp=0.
  - busy low again in cycle 3.
- req1 MUL a=6 b=9 (MUL_CYCLES=3):
  - alu_op=4'b0010 for exactly 3 cycles.
  - resp_data=54, resp_id=1, resp_valid in cycle T+4.
- Both ports valid for 6 grants:
  - resp_id sequence is 0,1,0,1,0,1.
  - No port is granted twice in a row while the other is valid.
- req0 compare a=3 b=8, then resp_ready held low for 5 cycles:
  - resp_valid and resp_data=36'hFFFFFFFFB are held stable, resp_cmp=1.
  - ALU lz=1, ez=0.
  - alu_op=0 throughout the stall.
  - req1_ready stays low until the handshake.
- rst pulsed for 1 cycle during EXEC of a MUL:
  - Next cycle: state IDLE, busy=0, resp_valid=0.
  - No response is ever emitted for the dropped op.
  - The next request from port 0 is granted first.
- req0 op 4'b1111 a=1 b=1 → resp_data=0, resp_cmp=1, handshake completes normally.
